// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller:
// forwarding selects and sequencer state encoding.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
// master = pipeline registers, slave = controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_redirect;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;
    logic             dm_req;
    logic             dm_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_memread, ex_redirect,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output dm_req, dm_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, fwd_a, fwd_b, err,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_memread, ex_redirect,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  dm_req, dm_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, fwd_a, fwd_b, err,
        output stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding compare for one operand.
// MEM result is younger than WB, so it wins; x0 never forwards.
import pipe_ctrl_pkg::*;

module fwd_unit (
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_regwrite,
    output logic [1:0] o_sel
);
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_regwrite && (i_mem_rd != 5'd0)
                       && (i_mem_rd == i_ex_rs);
    assign w_wb_hit  = i_wb_regwrite && (i_wb_rd != 5'd0)
                       && (i_wb_rd == i_ex_rs);

    // pick the youngest producer of the operand
    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit)
            o_sel = FWD_MEM;
        else if (w_wb_hit)
            o_sel = FWD_WB;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: stage enables, flushes, forwarding.
// Optional perf counters: define PIPE_PERF_CNT_EN.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rstn,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       w_hold;
    logic       w_lu;
    logic       w_in_err;
    logic [4:0] w_en;
    logic       w_ifid_fl;
    logic       w_idex_fl;
    logic       w_redir_app;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_hold   = bus.dm_req & ~bus.dm_ready;
    assign w_in_err = (r_state == ST_ERR);
    assign w_lu     = bus.ex_memread && (bus.ex_rd != 5'd0)
                      && ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd))
                       || (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // priority: reset/ERR > memory hold > redirect > load-use > normal
    always_comb begin
        w_en        = 5'b00000;
        w_ifid_fl   = 1'b0;
        w_idex_fl   = 1'b0;
        w_redir_app = 1'b0;
        if (!rstn || w_in_err || w_hold) begin
            w_en = 5'b00000;
        end else if (bus.ex_redirect) begin
            w_en        = 5'b11111;
            w_ifid_fl   = 1'b1;
            w_idex_fl   = 1'b1;
            w_redir_app = 1'b1;
        end else if (w_lu) begin
            w_en      = 5'b00111;
            w_idex_fl = 1'b1;
        end else begin
            w_en = 5'b11111;
        end
    end

    // RUN -> MEM_WAIT on a stalled access, MEM_WAIT -> ERR on timeout
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hold) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_hold) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ERR: r_state <= ST_ERR;
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    fwd_unit u_fwd_a (
        .i_ex_rs        (bus.ex_rs1),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_regwrite  (bus.wb_regwrite),
        .o_sel          (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_ex_rs        (bus.ex_rs2),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_regwrite  (bus.wb_regwrite),
        .o_sel          (w_fwd_b)
    );

    assign bus.pc_en      = w_en[4];
    assign bus.ifid_en    = w_en[3];
    assign bus.idex_en    = w_en[2];
    assign bus.exmem_en   = w_en[1];
    assign bus.memwb_en   = w_en[0];
    assign bus.ifid_flush = w_ifid_fl;
    assign bus.idex_flush = w_idex_fl;
    assign bus.fwd_a      = rstn ? w_fwd_a : FWD_RF;
    assign bus.fwd_b      = rstn ? w_fwd_b : FWD_RF;
    assign bus.err        = w_in_err;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // count frozen-PC cycles and applied redirects, wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_en[4])
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_redir_app)
                r_flush_events <= r_flush_events + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`else
    logic w_unused;
    assign w_unused         = w_redir_app;
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). It generates per-stage register enables, flushes and EX-operand forwarding selects. It handles load-use hazards, EX-resolved redirects (taken branch, jal, jalr) and multi-cycle data-memory waits, including a timeout-to-error state. It sits beside the decoder and consumes the RegWrite/MemRead/NPCOp-derived signals carried down the pipeline registers.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before entering ERR (legal range 2..255)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
ex_rd  in  5  EX destination
ex_memread  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch/jal/jalr this cycle
mem_rd  in  5  MEM destination
mem_regwrite  in  1  MEM writes the register file
wb_rd  in  5  WB destination
wb_regwrite  in  1  WB writes the register file
dm_req  in  1  MEM stage is accessing data memory
dm_ready  in  1  data memory completes the access this cycle
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
ifid_flush, idex_flush  out  1 each  load a bubble (nop) into IF/ID or ID/EX
fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 WB, 10 MEM
err  out  1  sticky memory-timeout error
stall_cycles, flush_events  out  CNT_W each  performance counters

Behaviour:
- Clock is clk. Reset is rstn, asynchronous and active-low.
- While rstn=0: state=RUN, wait_cnt=0, err=0, counters=0, all enables 0, all flushes 0, fwd_a=fwd_b=00.
- State register: RUN, MEM_WAIT, ERR.
- mem_hold = dm_req & ~dm_ready.
- Priority within a cycle, highest first: ERR > mem_hold > ex_redirect > load-use > normal.
- ERR: all enables 0, flushes 0, err=1. Exit only by reset.
- mem_hold (in RUN or MEM_WAIT): all five enables 0 and flushes 0, so the whole pipeline freezes and ex_redirect is held for later.
- RUN + mem_hold: go to MEM_WAIT next cycle with wait_cnt=1.
- MEM_WAIT:
  - dm_ready=1 -> RUN. That cycle applies the lower-priority rules (redirect/load-use) normally.
  - Otherwise wait_cnt++; when wait_cnt==MEM_TIMEOUT-1 and still not ready -> ERR.
- dm_ready in the same cycle as dm_req: zero wait, stays RUN.
- ex_redirect (not held): all enables 1, ifid_flush=1, idex_flush=1, i.e. two bubbles. The NPC loads the target.
- Load-use: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1, other enables 1.
  - Exactly one bubble. The next cycle the load is in MEM and forwarding covers the dependency.
- Load-use in the same cycle as ex_redirect: redirect wins (the ID instruction is wrong-path).
- Normal: all enables 1, flushes 0.
- Forwarding (combinational, independent of stalls):
  - fwd_a=10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Otherwise 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Otherwise 00. fwd_b likewise with ex_rs2.
  - MEM beats WB on a double match. x0 is never forwarded.
- Reset asserted mid-MEM_WAIT or in ERR: immediate return to RUN on assertion.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - stall_cycles increments each cycle pc_en=0 with rstn high, covering mem_hold, load-use and ERR.
  - flush_events increments each cycle ex_redirect is applied.
  - Both wrap at 2^CNT_W.
- Undefined: both outputs tied to 0 and no counter flops are synthesized. Ports remain.

Decomposition:
- Package pipe_ctrl_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - state encoding ST_RUN, ST_MEM_WAIT, ST_ERR
- Sub-module fwd_unit: the pure combinational forwarding compare, instantiated once per operand (a, b).

Test Plan:
- lw x5 in EX (ex_memread=1, ex_rd=5), ID add reads x5 via rs2 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle fwd_b=10.
- ex_redirect=1 with a load-use condition also true -> ifid_flush=1, idex_flush=1, pc_en=1; flush_events +1 if PIPE_PERF_CNT_EN.
- dm_req=1, dm_ready low for 3 cycles then high -> enables 0 for 3 cycles; state RUN->MEM_WAIT->RUN; a held ex_redirect is applied on the ready cycle.
- dm_req=1, dm_ready never asserted, MEM_TIMEOUT=16 -> err=1 after 16 stalled cycles, enables stay 0. Pulse rstn low -> err=0, state RUN.
- mem_rd=wb_rd=ex_rs1=7, both regwrite=1 -> fwd_a=10. ex_rs1=0 with mem_rd=0, mem_regwrite=1 -> fwd_a=00.
- Assert rstn low asynchronously mid-MEM_WAIT -> outputs go to reset values before the next clk edge.
